uart_tx_sched: RTL and testbench

Transmit-side controller for the UART channel. It shares one serial transmitter among `NREQ` byte requesters using round-robin arbitration. It sequences start, data, optional parity and stop bits on the per-bit `xmit_pulse` from the UART clock generator. It is also the only block that drives that generator's `baud_val`, and it changes the divider only between frames.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rr_arb.sv | 34 +++
 rtl/uart_tx_sched.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  // XOR masks applied to the data reduction to form the parity bit
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_e;

  // Parity bit that makes data+parity even (odd = 0) or odd (odd = 1) in ones
  function automatic logic uart_par_bit(input logic [UART_DATA_W-1:0] data, input logic odd);
    return (^data) ^ (odd ? PAR_ODD : PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin search: first request at or above the pointer, wrapping.
module uart_rr_arb #(
  parameter int unsigned  NREQ = 4,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IdxW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IdxW-1:0] o_idx,
  output logic            o_valid
);

  // Wrap pointer+offset back into 0..NREQ-1
  function automatic int unsigned wrap_pos(input int unsigned ptr, input int unsigned ofs);
    int unsigned sum;
    sum = ptr + ofs;
    return (sum >= NREQ) ? (sum - NREQ) : sum;
  endfunction

  // Priority search starting at the pointer; the first hit wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!o_valid && i_req[wrap_pos(32'(i_ptr), k)]) begin
        o_valid                       = 1'b1;
        o_gnt[wrap_pos(32'(i_ptr), k)] = 1'b1;
        o_idx                         = IdxW'(wrap_pos(32'(i_ptr), k));
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: arbitrates requesters, serialises frames, owns the baud divider.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned  NREQ   = 4,
  parameter int unsigned  DATA_W = 8,
  localparam int unsigned IdxW   = $clog2(NREQ)
) (
  input  logic                     clk_sys,
  input  logic                     rst_sys_n,
  input  logic                     xmit_pulse,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic [8:0]               cfg_baud_val,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  output logic [8:0]               baud_val,
  output logic                     txd,
  output logic                     tx_busy,
  output logic [IdxW-1:0]          tx_owner
);

  uart_tx_state_e         r_state, w_state_nxt;
  logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
  logic [2:0]             r_bit_cnt, w_bit_cnt_nxt;
  logic                   r_par_en, w_par_en_nxt;
  logic                   r_par_bit, w_par_bit_nxt;
  logic                   r_txd, w_txd_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [NREQ-1:0]        r_ready, w_ready_nxt;
  logic [IdxW-1:0]        r_owner, w_owner_nxt;
  logic [IdxW-1:0]        r_rr_ptr, w_rr_ptr_nxt;
  logic [8:0]             r_baud, w_baud_nxt;

  logic [NREQ-1:0]        w_gnt;
  logic [IdxW-1:0]        w_gnt_idx;
  logic                   w_any_req;
  logic [UART_DATA_W-1:0] w_req_byte;

  uart_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_any_req)
  );

  assign w_req_byte = req_data[w_gnt_idx*DATA_W +: UART_DATA_W];

  // Next-state, datapath and registered-output decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_en_nxt  = r_par_en;
    w_par_bit_nxt = r_par_bit;
    w_txd_nxt     = r_txd;
    w_busy_nxt    = r_busy;
    w_ready_nxt   = '0;
    w_owner_nxt   = r_owner;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_baud_nxt    = r_baud;

    case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_nxt   = StArm;
          w_shift_nxt   = w_req_byte;
          w_par_en_nxt  = cfg_parity_en;
          // Parity is resolved now so later config changes cannot affect this frame
          w_par_bit_nxt = uart_par_bit(w_req_byte, cfg_parity_odd);
          w_owner_nxt   = w_gnt_idx;
          w_rr_ptr_nxt  = (w_gnt_idx == IdxW'(NREQ - 1)) ? '0 : w_gnt_idx + IdxW'(1);
          w_ready_nxt   = w_gnt;
          w_busy_nxt    = 1'b1;
        end else begin
          // Divider only tracks config while the line is truly idle
          w_baud_nxt = cfg_baud_val;
        end
      end
      StArm: begin
        if (xmit_pulse) begin
          w_state_nxt = StStart;
          w_txd_nxt   = 1'b0;
        end
      end
      StStart: begin
        if (xmit_pulse) begin
          w_state_nxt   = StData;
          w_txd_nxt     = r_shift[0];
          w_shift_nxt   = r_shift >> 1;
          w_bit_cnt_nxt = 3'd0;
        end
      end
      StData: begin
        if (xmit_pulse) begin
          if (r_bit_cnt != 3'd7) begin
            w_txd_nxt     = r_shift[0];
            w_shift_nxt   = r_shift >> 1;
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end else if (r_par_en) begin
            w_state_nxt = StParity;
            w_txd_nxt   = r_par_bit;
          end else begin
            w_state_nxt = StStop;
            w_txd_nxt   = 1'b1;
          end
        end
      end
      StParity: begin
        if (xmit_pulse) begin
          w_state_nxt = StStop;
          w_txd_nxt   = 1'b1;
        end
      end
      StStop: begin
        if (xmit_pulse) begin
          w_state_nxt = StIdle;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_txd_nxt   = 1'b1;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset forces the line high immediately
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_ready   <= '0;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_baud    <= 9'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par_en  <= w_par_en_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= w_busy_nxt;
      r_ready   <= w_ready_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_baud    <= w_baud_nxt;
    end
  end

  assign req_ready = r_ready;
  assign baud_val  = r_baud;
  assign txd       = r_txd;
  assign tx_busy   = r_busy;
  assign tx_owner  = r_owner;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched.
module tb_uart_tx_sched;

  localparam int unsigned NREQ = 4;

  logic          clk_sys;
  logic          rst_sys_n;
  logic          xmit_pulse;
  logic [3:0]    req_valid;
  logic [31:0]   req_data;
  logic [3:0]    req_ready;
  logic [8:0]    cfg_baud_val;
  logic          cfg_parity_en;
  logic          cfg_parity_odd;
  logic [8:0]    baud_val;
  logic          txd;
  logic          tx_busy;
  logic [1:0]    tx_owner;

  int n_checks = 0;
  int n_errors = 0;

  logic cap_q[$];
  int   gnt_q[$];
  int   own_q[$];
  int   rdy_cnt[4];
  int   txd_low = 0;
  logic cap_all;

  uart_tx_sched #(
    .NREQ   (NREQ),
    .DATA_W (8)
  ) dut (
    .clk_sys        (clk_sys),
    .rst_sys_n      (rst_sys_n),
    .xmit_pulse     (xmit_pulse),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .cfg_baud_val   (cfg_baud_val),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .baud_val       (baud_val),
    .txd            (txd),
    .tx_busy        (tx_busy),
    .tx_owner       (tx_owner)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Bit-time strobe, one cycle every 16 clocks
  initial begin
    xmit_pulse = 1'b0;
    forever begin
      repeat (15) @(negedge clk_sys);
      xmit_pulse = 1'b1;
      @(negedge clk_sys);
      xmit_pulse = 1'b0;
    end
  end

  // Record txd after every strobe taken while a frame is in flight
  initial begin
    forever begin
      @(negedge clk_sys);
      #1;
      if (xmit_pulse && (tx_busy || cap_all)) begin
        @(posedge clk_sys);
        #1;
        cap_q.push_back(txd);
      end
    end
  end

  // Record grants, owners and line-low cycles
  initial begin
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    forever begin
      @(posedge clk_sys);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i]) begin
          gnt_q.push_back(i);
          own_q.push_back(int'(tx_owner));
          rdy_cnt[i]++;
        end
      end
      if (!txd) txd_low++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_caps();
    logic [31:0] v;
    v = '0;
    foreach (cap_q[i]) v = {v[30:0], cap_q[i]};
    return v;
  endfunction

  function automatic logic [31:0] pack_ints(input int q[$]);
    logic [31:0] v;
    v = '0;
    foreach (q[i]) v = {v[27:0], 4'(q[i])};
    return v;
  endfunction

  // Present a byte from one requester and drop valid once accepted
  task automatic send(input int r, input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    req_data[r*8 +: 8] = b;
    req_valid[r]       = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk_sys);
      if (req_ready[r]) begin
        seen = 1'b1;
        break;
      end
    end
    req_valid[r] = 1'b0;
    check("grant_wait", {31'd0, seen}, 32'd1);
  endtask

  // Returns at the first idle cycle after the current frame
  task automatic wait_idle();
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk_sys);
      if (!tx_busy) break;
    end
    check("idle_wait", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic wait_caps(input int n);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk_sys);
      if (cap_q.size() >= n) break;
    end
    check("cap_wait", {31'd0, cap_q.size() >= n}, 32'd1);
  endtask

  int r1_before;
  int low_before;

  initial begin
    rst_sys_n      = 1'b0;
    req_valid      = '0;
    req_data       = '0;
    cfg_baud_val   = 9'd0;
    cfg_parity_en  = 1'b0;
    cfg_parity_odd = 1'b0;
    cap_all        = 1'b0;
    repeat (3) @(negedge clk_sys);

    // Reset values
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_owner", {30'd0, tx_owner}, 32'd0);
    check("rst_baud", {23'd0, baud_val}, 32'd0);
    rst_sys_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Requester 0, 8'hA5, no parity: start, 1,0,1,0,0,1,0,1, stop, idle
    cap_q.delete();
    send(0, 8'hA5);
    wait_idle();
    check("a5_bits", pack_caps(), 32'h297);
    check("a5_len", cap_q.size(), 32'd11);
    check("a5_ready_once", rdy_cnt[0], 32'd1);
    check("a5_txd_idle", {31'd0, txd}, 32'd1);

    // 8'h01 even parity (bit 1); parity mode flipped mid-frame must be ignored
    cfg_parity_en  = 1'b1;
    cfg_parity_odd = 1'b0;
    cap_q.delete();
    send(1, 8'h01);
    cfg_parity_odd = 1'b1;
    wait_idle();
    check("even_bits", pack_caps(), 32'h407);
    check("even_len", cap_q.size(), 32'd12);
    check("even_owner", {30'd0, tx_owner}, 32'd1);

    // 8'h01 odd parity (bit 0); disabling parity mid-frame must be ignored
    cap_q.delete();
    send(1, 8'h01);
    cfg_parity_en = 1'b0;
    wait_idle();
    check("odd_bits", pack_caps(), 32'h403);
    check("odd_len", cap_q.size(), 32'd12);

    // Baud divider holds for the whole frame
    cfg_baud_val = 9'd1;
    repeat (2) @(negedge clk_sys);
    check("baud_idle", {23'd0, baud_val}, 32'd1);
    cap_q.delete();
    send(3, 8'h3C);
    check("baud_owner", {30'd0, tx_owner}, 32'd3);
    wait_caps(4);
    cfg_baud_val = 9'd3;
    repeat (3) @(negedge clk_sys);
    check("baud_mid", {23'd0, baud_val}, 32'd1);
    wait_idle();
    check("baud_stop_exit", {23'd0, baud_val}, 32'd1);
    @(negedge clk_sys);
    check("baud_reload", {23'd0, baud_val}, 32'd3);

    // Requester 2 back-to-back 8'h00 then 8'hFF, every strobe recorded
    cap_q.delete();
    send(2, 8'h00);
    cap_all = 1'b1;
    send(2, 8'hFF);
    wait_idle();
    cap_all = 1'b0;
    check("b2b_bits", pack_caps(), 32'h001BFF);
    check("b2b_len", cap_q.size(), 32'd22);
    check("b2b_ready", rdy_cnt[2], 32'd2);

    // Round robin from a fresh pointer with all requesters holding valid
    rst_sys_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    gnt_q.delete();
    own_q.delete();
    req_data  = 32'h44332211;
    req_valid = 4'hF;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk_sys);
      if (gnt_q.size() >= 5) break;
    end
    req_valid = 4'h0;
    check("rr_count", gnt_q.size(), 32'd5);
    wait_idle();
    check("rr_order", pack_ints(gnt_q), 32'h01230);
    check("rr_owner", pack_ints(own_q), 32'h01230);

    // Reset during DATA forces the line high at once and drops the frame
    cap_q.delete();
    send(1, 8'h00);
    wait_caps(3);
    @(negedge clk_sys);
    check("mid_txd_low", {31'd0, txd}, 32'd0);
    check("mid_busy", {31'd0, tx_busy}, 32'd1);
    #2;
    rst_sys_n = 1'b0;
    #1;
    check("async_txd", {31'd0, txd}, 32'd1);
    check("async_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk_sys);
    rst_sys_n  = 1'b1;
    r1_before  = rdy_cnt[1];
    low_before = txd_low;
    repeat (400) @(negedge clk_sys);
    check("post_rst_no_grant", rdy_cnt[1], r1_before);
    check("post_rst_line_high", txd_low, low_before);
    check("post_rst_busy", {31'd0, tx_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
